// File: rtl/seq_tx_111.sv
// Serial "111"-sync frame transmitter: sync, MSB-first payload with optional zero stuffing, idle gap.
// Latency: first sync bit on dout the cycle after accept; frame is 3 + DATA_W + S + GAP_CYCLES cycles.
// Backpressure: ready_out is high only in IDLE; valid_in outside IDLE is ignored (no queuing).
//
// Ports:
//   clk       - single clock, rising-edge
//   rst       - asynchronous active-high reset
//   data_in   - payload word, captured on valid_in && ready_out
//   valid_in  - payload request
//   ready_out - high when in IDLE (decoded from state only)
//   dout      - registered serial line
//   done      - registered one-cycle pulse on the final GAP cycle
//   state     - FSM state: IDLE=0, SYNC=1, DATA=2, STUFF=3, GAP=4
//
// Build option: define SEQTX_STUFF_EN to enable zero stuffing after every two
// consecutive payload ones, so "111" only ever appears as the sync field.
module seq_tx_111 #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              dout,
  output logic              done,
  output logic [2:0]        state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SYNC  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STUFF = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam int BW = $clog2(DATA_W + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_ALL  = BW'(DATA_W);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [1:0]        sync_cnt_q, sync_cnt_d;
  logic              dout_q, dout_d;
  logic              done_q, done_d;
`ifdef SEQTX_STUFF_EN
  logic [1:0]        run_q, run_d;
`endif

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    sync_cnt_d = sync_cnt_q;
`ifdef SEQTX_STUFF_EN
    run_d      = run_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          state_d    = ST_SYNC;
          sreg_d     = data_in;
          sync_cnt_d = 2'd0;
          bit_cnt_d  = '0;
          gap_cnt_d  = '0;
`ifdef SEQTX_STUFF_EN
          run_d      = 2'd0;
`endif
        end
      end

      ST_SYNC: begin
        if (sync_cnt_q == 2'd2) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
`ifdef SEQTX_STUFF_EN
          run_d     = 2'd0;
`endif
        end else begin
          sync_cnt_d = sync_cnt_q + 2'd1;
        end
      end

      ST_DATA: begin
        // The bit on dout this cycle is sreg_q's MSB; shift to expose the next one.
        sreg_d    = sreg_q << 1;
        bit_cnt_d = bit_cnt_q + BW'(1);
`ifdef SEQTX_STUFF_EN
        run_d = sreg_q[DATA_W-1] ? run_q + 2'd1 : 2'd0;
        // Two ones just went out: a third would mimic sync, so insert a zero.
        if (run_d == 2'd2) begin
          state_d = ST_STUFF;
        end else if (bit_cnt_q == BIT_LAST) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
`else
        if (bit_cnt_q == BIT_LAST) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
`endif
      end

      ST_STUFF: begin
`ifdef SEQTX_STUFF_EN
        run_d = 2'd0;
`endif
        // bit_cnt already counts the bit sent before the stuff.
        if (bit_cnt_q == BIT_ALL) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are computed from next-state values so the registered line is
  // aligned with the registered state: dout during DATA is that cycle's MSB.
  always_comb begin
    dout_d = (state_d == ST_SYNC) || ((state_d == ST_DATA) && sreg_d[DATA_W-1]);
    done_d = (state_d == ST_GAP) && (gap_cnt_d == GAP_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      sync_cnt_q <= 2'd0;
      dout_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SEQTX_STUFF_EN
      run_q      <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
`ifdef SEQTX_STUFF_EN
      run_q      <= run_d;
`endif
    end
  end

  assign ready_out = (state_q == ST_IDLE);
  assign dout      = dout_q;
  assign done      = done_q;
  assign state     = state_q;

endmodule
